// File: rtl/mac_control_unit_if.sv
// Signal bundle between mac_control_unit, its host, the operand file and the MAC.
// The slave modport is the controller's view; the master modport is the environment's view.
// With MAC_CTRL_PERF_EN defined, the bundle also carries the perf_cycles counter.
interface mac_control_unit_if #(
  parameter int unsigned LEN_W = 4
);
  // Host control/status
  logic             start;
  logic             op_mode;
  logic [LEN_W-1:0] length;
  logic [7:0]       x_in;
  logic             busy;
  logic             done;
  logic [16:0]      result;
`ifdef MAC_CTRL_PERF_EN
  logic [15:0]      perf_cycles;
`endif
  // Operand file
  logic [LEN_W-1:0] rd_addr;
  logic [7:0]       op_a;
  logic [7:0]       op_b;
  // MAC datapath
  logic [7:0]       mac_in_1;
  logic [7:0]       mac_in_2;
  logic [7:0]       mac_in_add;
  logic             mac_mode;
  logic             mac_mul_sel;
  logic             mac_add_sel;
  logic [16:0]      mac_result;

  modport slave (
`ifdef MAC_CTRL_PERF_EN
    output perf_cycles,
`endif
    input  start, op_mode, length, x_in, op_a, op_b, mac_result,
    output busy, done, result, rd_addr,
    output mac_in_1, mac_in_2, mac_in_add, mac_mode, mac_mul_sel, mac_add_sel
  );

  modport master (
`ifdef MAC_CTRL_PERF_EN
    input  perf_cycles,
`endif
    output start, op_mode, length, x_in, op_a, op_b, mac_result,
    input  busy, done, result, rd_addr,
    input  mac_in_1, mac_in_2, mac_in_add, mac_mode, mac_mul_sel, mac_add_sel
  );
endinterface

// File: rtl/mac_control_unit.sv
// Sequencer for the 8x8 MAC: issues one term every two cycles (ISSUE/WAIT), then
// captures the 17-bit MAC output and pulses done. Supports sum-of-products (op_mode=0)
// and Horner polynomial evaluation (op_mode=1).
// Optional: define MAC_CTRL_PERF_EN to add the perf_cycles busy-cycle counter.
module mac_control_unit #(
  parameter int unsigned LEN_W = 4
) (
  input logic          clk,
  input logic          reset,
  mac_control_unit_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StFinish} state_e;

  localparam logic [LEN_W-1:0] One = LEN_W'(1);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] k_q, k_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             mode_q, mode_d;
  logic [7:0]       x_q, x_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [16:0]      result_q, result_d;
`ifdef MAC_CTRL_PERF_EN
  logic [15:0]      perf_q, perf_d;
`endif

  // Next-state, operand latching and result capture
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    mode_d   = mode_q;
    x_d      = x_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mode_d = bus.op_mode;
          len_d  = bus.length;
          x_d    = bus.x_in;
          k_d    = '0;
          if (bus.length == '0) begin
            // Empty operation completes immediately with a zero result
            result_d = '0;
            state_d  = StFinish;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (k_q < (len_q - One)) begin
          k_d     = k_q + One;
          state_d = StIssue;
        end else begin
          state_d = StCapture;
        end
      end
      StCapture: begin
        result_d = bus.mac_result;
        state_d  = StFinish;
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    busy_d = (state_d == StIssue) || (state_d == StWait) || (state_d == StCapture);
    done_d = (state_d == StFinish);
  end

`ifdef MAC_CTRL_PERF_EN
  // Busy-cycle counter: cleared on accepted start, saturating, held between operations
  always_comb begin
    perf_d = perf_q;
    if ((state_q == StIdle) && bus.start) begin
      perf_d = '0;
    end else if (busy_q && (perf_q != 16'hFFFF)) begin
      perf_d = perf_q + 16'd1;
    end
  end
`endif

  // Operand file address and MAC drive; everything outside ISSUE is a zero bubble
  always_comb begin
    bus.rd_addr     = '0;
    bus.mac_in_1    = '0;
    bus.mac_in_2    = '0;
    bus.mac_in_add  = '0;
    bus.mac_mul_sel = 1'b0;
    bus.mac_add_sel = 1'b0;
    if (state_q == StIssue) begin
      if (!mode_q) begin
        bus.rd_addr     = k_q;
        bus.mac_in_1    = bus.op_a;
        bus.mac_in_2    = bus.op_b;
        bus.mac_add_sel = (k_q != '0);
      end else begin
        // Horner walks coefficients from the top down
        bus.rd_addr    = len_q - One - k_q;
        bus.mac_in_add = bus.op_a;
        if (k_q != '0) begin
          bus.mac_in_2    = x_q;
          bus.mac_mul_sel = 1'b1;
        end
      end
    end
  end

  assign bus.mac_mode = mode_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
`ifdef MAC_CTRL_PERF_EN
  assign bus.perf_cycles = perf_q;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      k_q      <= '0;
      len_q    <= '0;
      mode_q   <= 1'b0;
      x_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
`ifdef MAC_CTRL_PERF_EN
      perf_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      len_q    <= len_d;
      mode_q   <= mode_d;
      x_q      <= x_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
`ifdef MAC_CTRL_PERF_EN
      perf_q   <= perf_d;
`endif
    end
  end

endmodule

// File: tb/tb_mac_control_unit.sv
// Bench for mac_control_unit: operand file and two-stage MAC model around the DUT,
// expected results queued at start and compared when done pulses.
module tb_mac_control_unit;

  localparam int unsigned LenW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mac_control_unit_if #(.LEN_W(LenW)) bus ();

  mac_control_unit #(.LEN_W(LenW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Asynchronous-read operand file
  logic [7:0] mem_a [16];
  logic [7:0] mem_b [16];
  assign bus.op_a = mem_a[bus.rd_addr];
  assign bus.op_b = mem_b[bus.rd_addr];

  // MAC model: inputs staged one cycle, output register updated the next, so a
  // term issued in cycle t is visible in cycle t+2. Zero bubbles do not disturb it.
  logic [16:0] mac_out;
  logic        busy_prev, s_v, s_ms, s_as;
  logic [7:0]  s_in1, s_in2, s_add;
  assign bus.mac_result = mac_out;

  function automatic logic [16:0] mac_step(input logic [16:0] fb, input logic [7:0] in1,
                                           input logic [7:0] in2, input logic [7:0] add,
                                           input logic ms, input logic as);
    logic [31:0] p;
    p = (ms ? 32'(fb) : 32'(in1)) * 32'(in2);
    p = p & 32'h0000FFFF;
    return 17'(p + (as ? 32'(fb) : 32'(add)));
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mac_out <= '0; busy_prev <= 1'b0; s_v <= 1'b0; s_ms <= 1'b0; s_as <= 1'b0;
      s_in1 <= '0; s_in2 <= '0; s_add <= '0;
    end else begin
      busy_prev <= bus.busy;
      s_v   <= (bus.busy && !busy_prev) || bus.mac_mul_sel || bus.mac_add_sel;
      s_in1 <= bus.mac_in_1;
      s_in2 <= bus.mac_in_2;
      s_add <= bus.mac_in_add;
      s_ms  <= bus.mac_mul_sel;
      s_as  <= bus.mac_add_sel;
      if (s_v) mac_out <= mac_step(mac_out, s_in1, s_in2, s_add, s_ms, s_as);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] sb_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Plain arithmetic references for randomised runs
  function automatic logic [16:0] ref_sop(input int n);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc += longint'(mem_a[i]) * longint'(mem_b[i]);
    return 17'(acc % 131072);
  endfunction

  function automatic logic [16:0] ref_poly(input int n, input logic [7:0] x);
    longint acc = longint'(mem_a[n-1]);
    for (int i = n - 2; i >= 0; i--) acc = ((acc * longint'(x)) % 65536 + longint'(mem_a[i])) % 131072;
    return 17'(acc);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_result"}, 32'(bus.result), 32'd0);
    check({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    check({tag, "_mac"}, {5'd0, bus.mac_in_1, bus.mac_in_2, bus.mac_in_add, bus.mac_mode,
                          bus.mac_mul_sel, bus.mac_add_sel}, 32'd0);
  endtask

  // One operation: start, then per-cycle checks of busy/done/address/bubbles.
  // repulse_at: cycle offset at which start is pulsed again with other settings.
  // rst_at: cycle offset at which reset is asserted (no result expected).
  task automatic run_op(input logic mode, input int n, input logic [7:0] x,
                        input int repulse_at, input int rst_at, input logic [16:0] exp_res);
    bit seen_done = 0;
    bit stop = 0;
    logic [16:0] last_res = '0;
    if (rst_at == 0) sb_q.push_back(exp_res);
    @(negedge clk);
    bus.start = 1'b1; bus.op_mode = mode; bus.length = LenW'(n); bus.x_in = x;
    for (int j = 1; j <= 2 * n + 6 && !stop; j++) begin
      @(negedge clk);
      if (j == 1) bus.start = 1'b0;
      if (j == repulse_at) begin
        bus.start = 1'b1; bus.op_mode = ~mode; bus.length = LenW'(5); bus.x_in = 8'd7;
      end
      if (j == repulse_at + 1) bus.start = 1'b0;
      check("busy", 32'(bus.busy), 32'((n != 0) && (j <= 2 * n + 1)));
      check("done", 32'(bus.done), 32'(j == ((n == 0) ? 1 : 2 * n + 2)));
      if (n != 0 && j <= 2 * n + 1) check("mac_mode", 32'(bus.mac_mode), 32'(mode));
      if (n != 0 && j <= 2 * n && (j % 2) == 1) begin
        check("rd_addr", 32'(bus.rd_addr), mode ? 32'(n - 1 - (j - 1) / 2) : 32'((j - 1) / 2));
      end else if (n != 0 && j <= 2 * n + 1) begin
        check("bubble", {7'd0, bus.mac_in_1, bus.mac_in_2, bus.mac_in_add, bus.mac_mul_sel,
                         bus.mac_add_sel}, 32'd0);
      end
      if (bus.done) begin
        seen_done = 1;
        if (sb_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          last_res = sb_q.pop_front();
          check("result", 32'(bus.result), 32'(last_res));
        end
`ifdef MAC_CTRL_PERF_EN
        check("perf_cycles", 32'(bus.perf_cycles), (n == 0) ? 32'd0 : 32'(2 * n + 1));
`endif
      end else if (seen_done) begin
        check("result_hold", 32'(bus.result), 32'(last_res));
      end
      if (j == rst_at) begin
        reset = 1'b1;
        #1;
        check_idle_outputs("midreset");
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("midreset_done", 32'(bus.done), 32'd0);
        end
        reset = 1'b0;
        stop = 1;
      end
    end
    bus.start = 1'b0;
    if (rst_at == 0) check("done_seen", 32'(seen_done), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] xr;
    reset = 1'b1;
    bus.start = 1'b0; bus.op_mode = 1'b0; bus.length = '0; bus.x_in = '0;
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    // SOP basic
    mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3;
    mem_b[0] = 8'd4; mem_b[1] = 8'd5; mem_b[2] = 8'd6;
    run_op(1'b0, 3, 8'd0, 0, 0, 17'd32);
    // POLY basic: 5x^2 + 3x + 1 at x=2
    mem_a[0] = 8'd1; mem_a[1] = 8'd3; mem_a[2] = 8'd5;
    run_op(1'b1, 3, 8'd2, 0, 0, 17'd27);
    // SOP wrap and POLY truncation
    for (int i = 0; i < 3; i++) begin mem_a[i] = 8'd255; mem_b[i] = 8'd255; end
    run_op(1'b0, 3, 8'd0, 0, 0, 17'd64003);
    run_op(1'b1, 3, 8'd255, 0, 0, 17'd511);
    // Empty operation
    run_op(1'b0, 0, 8'd0, 0, 0, 17'd0);

    mem_a[0] = 8'd1; mem_a[1] = 8'd2; mem_a[2] = 8'd3;
    mem_b[0] = 8'd4; mem_b[1] = 8'd5; mem_b[2] = 8'd6;
    // start during busy ignored; start during FINISH ignored
    run_op(1'b0, 3, 8'd0, 3, 0, 17'd32);
    run_op(1'b0, 3, 8'd0, 8, 0, 17'd32);
    // Reset mid-operation, then a clean run
    run_op(1'b0, 3, 8'd0, 0, 3, 17'd0);
    run_op(1'b0, 3, 8'd0, 0, 0, 17'd32);

    // Randomised full-length-range runs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        mem_a[i] = 8'($urandom_range(0, 255));
        mem_b[i] = 8'($urandom_range(0, 255));
      end
      n  = $urandom_range(1, 15);
      xr = 8'($urandom_range(0, 255));
      if (r % 2 == 0) run_op(1'b0, n, 8'd0, 0, 0, ref_sop(n));
      else            run_op(1'b1, n, xr, 0, 0, ref_poly(n, xr));
    end
    n = 15;
    run_op(1'b1, n, 8'd3, 0, 0, ref_poly(n, 8'd3));

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
